mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; reset_n input 1, asynchronous active-low reset.
REQ-002 The block SHALL have these further ports:
- start input 1: E-stage multiply/divide launch strobe (the same signal the stall unit uses).
- op input 4: operation code (encodings in mdu_pkg).
- a input 32: rs operand.
- b input 32: rt operand.
- busy output 1: operation in flight; drives the stall unit.
- hi output 32: HI register.
- lo output 32: LO register.

Function
REQ-003 Op encodings SHALL be: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8, MSUB=9, MSUBU=10; other codes SHALL behave as NOP.
REQ-004 On a rising edge with start=1, busy=0 and op in {MULT, MULTU, DIV, DIVU, MADD*, MSUB*}, the block SHALL latch a, b, op and load the counter with MUL_LAT=5 for multiply-class ops or DIV_LAT=10 for divide ops.
REQ-005 busy SHALL equal (counter!=0), be registered, and stay high for exactly MUL_LAT or DIV_LAT cycles after the launch edge.
REQ-006 The counter SHALL decrement by 1 per edge while nonzero; on the edge where it goes 1->0, HI/LO SHALL be written, so the result is visible in the first cycle with busy=0.
REQ-007 Result rules:
- MULT: {hi,lo} = signed a*b, 64 bits.
- MULTU: {hi,lo} = unsigned a*b.
- DIV: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
- DIVU: unsigned quotient and remainder.
REQ-008 Divide by zero SHALL give lo=32'hFFFF_FFFF and hi=a; signed DIV of 32'h8000_0000 by 32'hFFFF_FFFF SHALL give lo=32'h8000_0000 and hi=0.
REQ-009 start=1 while busy=1 SHALL be ignored: no relaunch, no change to the latched operands or the counter.
REQ-010 MTHI/MTLO SHALL write a into hi/lo on the edge where start=0, busy=0 and op=MTHI/MTLO; while busy=1 they SHALL be ignored.
REQ-011 start=1 with op=MTHI/MTLO/NOP SHALL have no effect.
REQ-012 hi and lo SHALL be direct register outputs, with no combinational path from any input.

Reset
REQ-013 Asserting reset_n=0 SHALL immediately clear busy, the counter, hi, lo and the latched operands/op to 0, at any time.
REQ-014 Reset mid-operation SHALL discard the pending result; after release the block SHALL be idle and accept start on the first edge.

Configuration
REQ-015 Macro MDU_MADD_EN SHALL compile in the accumulate ops.
- Defined: the 64-bit result is {hi,lo} + product for MADD/MADDU, or {hi,lo} - product for MSUB/MSUBU (signed or unsigned product as named), with latency MUL_LAT, modulo 2^64.
- Not defined: op codes 7-10 SHALL be treated as NOP, and start with them SHALL NOT set busy.

Structure
REQ-016 mdu_pkg SHALL hold the op encodings, MUL_LAT, DIV_LAT and the counter width (4 bits).
REQ-017 The result arithmetic (product, quotient/remainder, accumulate) SHALL live in one combinational sub-module, mdu_arith, fed by the latched operands; mul_div_unit holds the counter, control and HI/LO.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- MULT, a=32'hFFFF_FFFE (-2), b=3 -> busy high exactly 5 cycles; then hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA.
- DIVU, a=7, b=2 -> busy high exactly 10 cycles; then lo=3, hi=1. DIV, a=-7, b=2 -> lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF.
- DIV, a=5, b=0 -> lo=32'hFFFF_FFFF, hi=5. DIV, a=32'h8000_0000, b=-1 -> lo=32'h8000_0000, hi=0.
- MULTU 3*4 launched, then start with DIVU in cycle 2 -> ignored; result hi=0, lo=12 after 5 cycles. MTLO a=9 while busy -> lo stays 12.
- reset_n pulsed low in cycle 3 of a DIV -> busy, hi, lo = 0 immediately and stay 0. Next MTHI a=32'h1234 -> hi=32'h1234 one edge later.
- With MDU_MADD_EN: hi=0, lo=10, then MADD a=2, b=3 -> lo=16 after 5 cycles. Without MDU_MADD_EN: same stimulus -> busy stays 0, hi/lo unchanged.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings, latencies and decode helpers for mul_div_unit.
// MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } op_e;

  localparam int CNT_W = 4;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t MUL_LAT = 4'd5;
  localparam cnt_t DIV_LAT = 4'd10;

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_acc(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return (op == OP_MADD) || (op == OP_MADDU) ||
           (op == OP_MSUB) || (op == OP_MSUBU);
`else
    return (op == 4'hF) && (op != 4'hF);
`endif
  endfunction

  function automatic logic is_mul(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || is_acc(op);
  endfunction

  function automatic logic is_launch(input logic [3:0] op);
    return is_mul(op) || is_div(op);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational product, quotient/remainder and accumulate.
// MDU_MADD_EN adds the accumulate paths using the current HI/LO.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  logic signed [63:0] w_sprod;
  logic [63:0]        w_uprod;
  logic               w_bz;
  logic               w_an;
  logic               w_bn;
  logic [31:0]        w_ma;
  logic [31:0]        w_mb;
  logic [31:0]        w_sden;
  logic [31:0]        w_uden;
  logic [31:0]        w_sq;
  logic [31:0]        w_sr;
  logic [31:0]        w_uq;
  logic [31:0]        w_ur;
  logic [63:0]        w_acc;

  assign w_sprod = $signed(i_a) * $signed(i_b);
  assign w_uprod = {32'd0, i_a} * {32'd0, i_b};
  assign w_acc   = {i_hi, i_lo};

  // Signed divide on magnitudes; sign fixed afterwards.
  // 0x80000000 / -1 falls out naturally as 0x80000000 rem 0.
  assign w_bz   = (i_b == 32'd0);
  assign w_an   = i_a[31];
  assign w_bn   = i_b[31];
  assign w_ma   = w_an ? (32'd0 - i_a) : i_a;
  assign w_mb   = w_bn ? (32'd0 - i_b) : i_b;
  assign w_sden = w_bz ? 32'd1 : w_mb;
  assign w_uden = w_bz ? 32'd1 : i_b;
  assign w_sq   = (w_an ^ w_bn) ? (32'd0 - (w_ma / w_sden))
                                : (w_ma / w_sden);
  assign w_sr   = w_an ? (32'd0 - (w_ma % w_sden))
                       : (w_ma % w_sden);
  assign w_uq   = i_a / w_uden;
  assign w_ur   = i_a % w_uden;

`ifndef MDU_MADD_EN
  logic w_unused;
  assign w_unused = ^w_acc;
`endif

  // Result select by latched op.
  always_comb begin
    o_hi = 32'd0;
    o_lo = 32'd0;
    unique case (1'b1)
      (i_op == OP_MULT): {o_hi, o_lo} = w_sprod;
      (i_op == OP_MULTU): {o_hi, o_lo} = w_uprod;
      (i_op == OP_DIV): begin
        o_lo = w_bz ? 32'hFFFF_FFFF : w_sq;
        o_hi = w_bz ? i_a : w_sr;
      end
      (i_op == OP_DIVU): begin
        o_lo = w_bz ? 32'hFFFF_FFFF : w_uq;
        o_hi = w_bz ? i_a : w_ur;
      end
`ifdef MDU_MADD_EN
      (i_op == OP_MADD): {o_hi, o_lo} = w_acc + w_sprod;
      (i_op == OP_MADDU): {o_hi, o_lo} = w_acc + w_uprod;
      (i_op == OP_MSUB): {o_hi, o_lo} = w_acc - w_sprod;
      (i_op == OP_MSUBU): {o_hi, o_lo} = w_acc - w_uprod;
`endif
      default: begin
        o_hi = 32'd0;
        o_lo = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: fixed-latency multiply/divide with HI/LO registers.
// MDU_MADD_EN compiles in MADD/MADDU/MSUB/MSUBU.
module mul_div_unit
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  cnt_t        r_cnt;
  logic        r_busy;
  logic [3:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_launch;
  logic        w_done;
  logic [31:0] w_hi;
  logic [31:0] w_lo;

  assign w_launch = start && !r_busy && is_launch(op);
  assign w_done   = r_busy && (r_cnt == cnt_t'(1));

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

  mdu_arith u_arith (
    .i_op (r_op),
    .i_a  (r_a),
    .i_b  (r_b),
    .i_hi (r_hi),
    .i_lo (r_lo),
    .o_hi (w_hi),
    .o_lo (w_lo)
  );

  // Launch latches operands and loads the latency counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_op   <= 4'd0;
      r_a    <= 32'd0;
      r_b    <= 32'd0;
    end else if (w_launch) begin
      r_op   <= op;
      r_a    <= a;
      r_b    <= b;
      r_cnt  <= is_div(op) ? DIV_LAT : MUL_LAT;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_cnt  <= r_cnt - cnt_t'(1);
      r_busy <= !w_done;
    end
  end

  // HI/LO: result on the final count, else idle MTHI/MTLO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (w_done) begin
      r_hi <= w_hi;
      r_lo <= w_lo;
    end else if (!start && !r_busy) begin
      if (op == OP_MTHI) r_hi <= a;
      if (op == OP_MTLO) r_lo <= a;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed scoreboard bench for mul_div_unit.
// Build with +define+MDU_MADD_EN to exercise the accumulate ops.
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  always #5 clk = ~clk;

  mul_div_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo)
  );

  typedef struct {
    string       tag;
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input string tag, input logic [3:0] o,
                        input logic [31:0] x, input logic [31:0] y,
                        input int cyc, input logic [31:0] eh,
                        input logic [31:0] el, input bit push);
    exp_t e;
    @(negedge clk);
    if (push) begin
      e.tag = tag; e.cyc = cyc; e.hi = eh; e.lo = el;
      sb.push_back(e);
    end
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
  endtask

  task automatic finish_op(input int n0);
    exp_t e;
    int n;
    n = n0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (sb.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, "_cyc"}, 64'(n), 64'(e.cyc));
    chk({e.tag, "_hi"}, {32'd0, hi}, {32'd0, e.hi});
    chk({e.tag, "_lo"}, {32'd0, lo}, {32'd0, e.lo});
  endtask

  task automatic run(input string tag, input logic [3:0] o,
                     input logic [31:0] x, input logic [31:0] y,
                     input int cyc, input logic [31:0] eh,
                     input logic [31:0] el);
    launch(tag, o, x, y, cyc, eh, el, 1'b1);
    finish_op(0);
  endtask

  task automatic mtx(input logic [3:0] o, input logic [31:0] x);
    @(negedge clk);
    start = 1'b0; op = o; a = x;
    @(negedge clk);
    op = OP_NOP;
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [63:0] pv;
    int          sa;
    int          sbv;
    longint      sp;

    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    reset_n = 1'b1;

    run("mult_m2x3", OP_MULT, 32'hFFFF_FFFE, 32'd3, 5,
        32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run("divu_7_2", OP_DIVU, 32'd7, 32'd2, 10, 32'd1, 32'd3);
    run("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 10,
        32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("div_5_0", OP_DIV, 32'd5, 32'd0, 10, 32'd5, 32'hFFFF_FFFF);
    run("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10,
        32'd0, 32'h8000_0000);
    run("divu_0", OP_DIVU, 32'hDEAD_0001, 32'd0, 10,
        32'hDEAD_0001, 32'hFFFF_FFFF);
    run("multu_3x4", OP_MULTU, 32'd3, 32'd4, 5, 32'd0, 32'd12);

    launch("multu_ign", OP_MULTU, 32'd3, 32'd4, 5, 32'd0, 32'd12, 1'b1);
    chk("ign_busy1", {63'd0, busy}, 64'd1);
    start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0; op = OP_MTLO; a = 32'd9;
    @(negedge clk);
    op = OP_NOP;
    chk("mtlo_busy_lo", {32'd0, lo}, 64'd12);
    chk("ign_busy3", {63'd0, busy}, 64'd1);
    finish_op(2);

    launch("div_rst", OP_DIV, 32'd100, 32'd7, 10, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    chk("rst_mid_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_stay", {31'd0, busy, hi, lo}, 64'd0);
    end
    mtx(OP_MTHI, 32'h1234);
    chk("mthi", {32'd0, hi}, 64'h1234);

    mtx(OP_MTHI, 32'd0);
    mtx(OP_MTLO, 32'd10);
    chk("mtlo10", {hi, lo}, 64'd10);
`ifdef MDU_MADD_EN
    run("madd", OP_MADD, 32'd2, 32'd3, 5, 32'd0, 32'd16);
    run("msub", OP_MSUB, 32'd1, 32'd1, 5, 32'd0, 32'd15);
    run("msubu_wrap", OP_MSUBU, 32'd4, 32'd4, 5,
        32'hFFFF_FFFF, 32'hFFFF_FFFF);
`else
    @(negedge clk);
    start = 1'b1; op = OP_MADD; a = 32'd2; b = 32'd3;
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
    chk("madd_off_busy", {63'd0, busy}, 64'd0);
    repeat (6) @(negedge clk);
    chk("madd_off_busy2", {63'd0, busy}, 64'd0);
    chk("madd_off_hilo", {hi, lo}, 64'd10);
`endif

    for (int i = 0; i < 3; i++) begin
      ra = $urandom; rb = $urandom;
      sa = ra; sbv = rb;
      sp = longint'(sa) * longint'(sbv);
      pv = sp;
      run("rnd_mult", OP_MULT, ra, rb, 5, pv[63:32], pv[31:0]);
      pv = {32'd0, ra} * {32'd0, rb};
      run("rnd_multu", OP_MULTU, ra, rb, 5, pv[63:32], pv[31:0]);
      rb = $urandom_range(1, 32'hFFFF);
      run("rnd_divu", OP_DIVU, ra, rb, 10, ra % rb, ra / rb);
      sbv = $urandom_range(1, 1000);
      if (i[0]) sbv = -sbv;
      sa = ra;
      run("rnd_div", OP_DIV, ra, sbv, 10, sa % sbv, sa / sbv);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
